// File: rtl/vga_pkg.sv
`timescale 1ns / 1ps
// Shared timing constants for the 1440x900@60 VGA path, plus the sync-window helper.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 1440;
    localparam int H_FP_DEF     = 80;
    localparam int H_SYNC_DEF   = 152;
    localparam int H_BP_DEF     = 232;
    localparam int V_ACTIVE_DEF = 900;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 25;

    localparam logic HS_POL_DEF = 1'b0;
    localparam logic VS_POL_DEF = 1'b1;

    localparam int POS_W         = 11;
    localparam int COUNT_W       = 6;
    localparam int COUNT_MAX_DEF = 59;
    localparam int BLINK_HALF    = 30;
    localparam int SYNC_DLY_DEF  = 2;

    // True when lo <= pos < lo+len.
    function automatic logic in_window(input logic [POS_W-1:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
`timescale 1ns / 1ps
// Single-bit shift register of configurable depth with a synchronous reset
// to a configurable level; used to re-align sync with the renderer pipeline.
module sig_delay #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_r;

    // Shift chain: stage 0 takes the input, each later stage takes its predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= {DEPTH{RST_VAL}};
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
`timescale 1ns / 1ps
// Free-running VGA raster timing generator: coordinates, syncs, active flag and blink counter.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync by SYNC_DLY extra register stages.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   H_FP      = H_FP_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BP      = H_BP_DEF,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter int   V_FP      = V_FP_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BP      = V_BP_DEF,
    parameter logic HS_POL    = HS_POL_DEF,
    parameter logic VS_POL    = VS_POL_DEF,
    parameter int   COUNT_MAX = COUNT_MAX_DEF
`ifdef VGA_SYNC_DELAY_EN
   ,parameter int   SYNC_DLY  = SYNC_DLY_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic [COUNT_W-1:0] count,
    output logic               frame_start
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;

    localparam logic [POS_W-1:0]   H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0]   V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]   POS_ZERO = {POS_W{1'b0}};
    localparam logic [POS_W-1:0]   POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(COUNT_MAX);
    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [POS_W-1:0]   pos_x_r, pos_y_r, x_next_s, y_next_s;
    logic [COUNT_W-1:0] count_r, count_next_s;
    logic               active_r, hsync_r, vsync_r, frame_start_r;
    logic               active_next_s, hsync_next_s, vsync_next_s, frame_start_next_s;

    // Next raster position, frame-start pulse and blink count.
    always_comb begin
        x_next_s           = pos_x_r;
        y_next_s           = pos_y_r;
        count_next_s       = count_r;
        frame_start_next_s = 1'b0;
        if (pos_x_r == H_LAST) begin
            x_next_s = POS_ZERO;
            if (pos_y_r == V_LAST) begin
                y_next_s = POS_ZERO;
            end else begin
                y_next_s = pos_y_r + POS_ONE;
            end
        end else begin
            x_next_s = pos_x_r + POS_ONE;
        end
        if ((x_next_s == POS_ZERO) && (y_next_s == POS_ZERO)) begin
            frame_start_next_s = 1'b1;
            if (count_r == CNT_LAST) begin
                count_next_s = CNT_ZERO;
            end else begin
                count_next_s = count_r + CNT_ONE;
            end
        end else begin
            frame_start_next_s = 1'b0;
        end
    end

    // Flags decoded from the next position so they land on the same edge as pos.
    always_comb begin
        active_next_s = (int'(x_next_s) < H_ACTIVE) && (int'(y_next_s) < V_ACTIVE);
        hsync_next_s  = in_window(x_next_s, H_SYNC_LO, H_SYNC) ? HS_POL : ~HS_POL;
        vsync_next_s  = in_window(y_next_s, V_SYNC_LO, V_SYNC) ? VS_POL : ~VS_POL;
    end

    // Output registers; reset parks the raster on the last pixel so release starts at (0, 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x_r       <= H_LAST;
            pos_y_r       <= V_LAST;
            count_r       <= CNT_LAST;
            active_r      <= 1'b0;
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            frame_start_r <= 1'b0;
        end else begin
            pos_x_r       <= x_next_s;
            pos_y_r       <= y_next_s;
            count_r       <= count_next_s;
            active_r      <= active_next_s;
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            frame_start_r <= frame_start_next_s;
        end
    end

    assign pos_x       = pos_x_r;
    assign pos_y       = pos_y_r;
    assign count       = count_r;
    assign active      = active_r;
    assign frame_start = frame_start_r;

`ifdef VGA_SYNC_DELAY_EN
    sig_delay #(.DEPTH(SYNC_DLY), .RST_VAL(~HS_POL)) u_hsync_dly (
        .clk (clk),
        .rst (rst),
        .d   (hsync_r),
        .q   (hsync)
    );

    sig_delay #(.DEPTH(SYNC_DLY), .RST_VAL(~VS_POL)) u_vsync_dly (
        .clk (clk),
        .rst (rst),
        .d   (vsync_r),
        .q   (vsync)
    );
`else
    assign hsync = hsync_r;
    assign vsync = vsync_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns / 1ps
// Randomised-reset bench: a shrunken-raster instance for whole-frame/blink behaviour
// and a default 1440x900 instance for the first lines, both against an arithmetic raster model.
module tb_vga_timing_gen;
    import vga_pkg::*;

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    typedef struct { int ha, hfp, hs, hbp, va, vfp, vs, vbp, cm; } tim_t;
    typedef struct { int x, y, act, hs, vs, cnt, fs; } exp_t;

    localparam tim_t TA = '{ha:16, hfp:3, hs:4, hbp:5, va:10, vfp:2, vs:3, vbp:4, cm:59};
    localparam tim_t TB = '{ha:1440, hfp:80, hs:152, hbp:232, va:900, vfp:3, vs:6, vbp:25, cm:59};
    localparam int FRAME_A = 28 * 19;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic [10:0] px_a, py_a, px_b, py_b;
    logic [5:0]  cnt_a, cnt_b;
    logic act_a, hs_a, vs_a, fs_a, act_b, hs_b, vs_b, fs_b;

    int n_cmp = 0, n_bad = 0;
    longint ka = -1, kb = -1, cyc = 0;
    longint last_fs = -1;
    int n_per = 0, frames_seen = 0, blink_low = 0, n_fall = 0, n_run = 0, run_len = 0;
    logic prev_hs_b = 1'b1;
    bit rand_phase = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4)
    ) dut_a (
        .clk(clk), .rst(rst_a), .pos_x(px_a), .pos_y(py_a), .active(act_a),
        .hsync(hs_a), .vsync(vs_a), .count(cnt_a), .frame_start(fs_a)
    );

    vga_timing_gen dut_b (
        .clk(clk), .rst(rst_b), .pos_x(px_b), .pos_y(py_b), .active(act_b),
        .hsync(hs_b), .vsync(vs_b), .count(cnt_b), .frame_start(fs_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // k = edges since reset release minus one; k < 0 means the generator is in reset.
    function automatic exp_t model(input tim_t t, input longint k);
        exp_t e;
        longint ht, vt, ks;
        int sx, sy;
        ht = t.ha + t.hfp + t.hs + t.hbp;
        vt = t.va + t.vfp + t.vs + t.vbp;
        if (k < 0) begin
            e.x = int'(ht - 1); e.y = int'(vt - 1); e.act = 0; e.cnt = t.cm; e.fs = 0;
        end else begin
            e.x   = int'(k % ht);
            e.y   = int'((k / ht) % vt);
            e.act = (e.x < t.ha && e.y < t.va) ? 1 : 0;
            e.cnt = int'((k / (ht * vt)) % (t.cm + 1));
            e.fs  = (e.x == 0 && e.y == 0) ? 1 : 0;
        end
        ks = k - DLY;
        if (ks < 0) begin
            e.hs = 1; e.vs = 0;
        end else begin
            sx = int'(ks % ht);
            sy = int'((ks / ht) % vt);
            e.hs = (sx >= t.ha + t.hfp && sx < t.ha + t.hfp + t.hs) ? 0 : 1;
            e.vs = (sy >= t.va + t.vfp && sy < t.va + t.vfp + t.vs) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic step();
        exp_t ea, eb;
        @(posedge clk);
        #1;
        cyc++;
        ka = rst_a ? -1 : ka + 1;
        kb = rst_b ? -1 : kb + 1;
        ea = model(TA, ka);
        eb = model(TB, kb);
        check("a_pos_x", 32'(px_a), ea.x);   check("a_pos_y", 32'(py_a), ea.y);
        check("a_active", 32'(act_a), ea.act); check("a_hsync", 32'(hs_a), ea.hs);
        check("a_vsync", 32'(vs_a), ea.vs);  check("a_count", 32'(cnt_a), ea.cnt);
        check("a_frame_start", 32'(fs_a), ea.fs);
        check("b_pos_x", 32'(px_b), eb.x);   check("b_pos_y", 32'(py_b), eb.y);
        check("b_active", 32'(act_b), eb.act); check("b_hsync", 32'(hs_b), eb.hs);
        check("b_vsync", 32'(vs_b), eb.vs);  check("b_count", 32'(cnt_b), eb.cnt);
        check("b_frame_start", 32'(fs_b), eb.fs);
        // Frame period and blink duty on the small raster.
        if (ka >= 0 && fs_a === 1'b1) begin
            if (!rand_phase && last_fs >= 0 && n_per < 3) begin
                check("fs_period", 32'(cyc - last_fs), FRAME_A);
                n_per++;
            end
            last_fs = cyc;
            if (frames_seen < 60) begin
                frames_seen++;
                if (int'(cnt_a) <= BLINK_HALF) blink_low++;
            end
        end
        // hsync fall position and pulse width on the full-size raster.
        if (kb >= 0) begin
            if (prev_hs_b === 1'b1 && hs_b === 1'b0 && n_fall < 2) begin
                check("hs_fall_x", 32'(px_b), 1520 + DLY);
                n_fall++;
            end
            if (hs_b === 1'b0) begin
                run_len++;
            end else if (run_len > 0) begin
                if (n_run < 2) begin
                    check("hs_width", run_len, 152);
                    n_run++;
                end
                run_len = 0;
            end
        end
        prev_hs_b = hs_b;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 62 * FRAME_A; i++) step();
        check("blink_low_frames", blink_low, 31);
        check("frames_seen", frames_seen, 60);
        rand_phase = 1'b1;
        for (int r = 0; r < 25; r++) begin
            int gap, len;
            gap = int'($urandom_range(1, 700));
            len = int'($urandom_range(1, 3));
            for (int i = 0; i < gap; i++) step();
            rst_a = 1'b1;
            for (int i = 0; i < len; i++) step();
            rst_a = 1'b0;
        end
        for (int i = 0; i < 600; i++) step();
        check("hs_fall_seen", n_fall, 2);
        check("hs_width_seen", n_run, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-clock timing generator for the game's VGA output.
- Produces raw scan coordinates, sync pulses, an active-video flag and the 60-frame blink counter.
- Its coordinates and counter drive every downstream renderer: background, pipes, ghost, score and the ending screen, including its `count <= 30` font blink.
- Sits directly upstream of the renderers and the final RGB mux.

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch (pixels)
- H_SYNC, 152, hsync pulse width (pixels)
- H_BP, 232, horizontal back porch (pixels)
- V_ACTIVE, 900, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 25, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 1, vsync asserted level
- COUNT_MAX, 59, blink counter wrap value
- SYNC_DLY, 2, extra sync delay in cycles (used only with the optional feature)

Ports:
- clk, in, 1, pixel clock (106.47 MHz for the defaults)
- rst, in, 1, synchronous reset, active-high
- pos_x, out, 11, horizontal counter, 0..H_TOTAL-1
- pos_y, out, 11, vertical counter, 0..V_TOTAL-1
- active, out, 1, high when pos_x < H_ACTIVE and pos_y < V_ACTIVE
- hsync, out, 1, horizontal sync to connector
- vsync, out, 1, vertical sync to connector
- count, out, 6, frame counter, 0..COUNT_MAX
- frame_start, out, 1, one-cycle pulse while (pos_x, pos_y) = (0, 0)

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 1904).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 934).
  - Both must fit in 11 bits.
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered.
- active, hsync, vsync and frame_start are decoded from the next-state counter values. They are therefore cycle-aligned with the pos_x/pos_y they describe, with zero skew.
- Counter rules:
  - pos_x increments every cycle and wraps from H_TOTAL-1 to 0.
  - On that wrap, pos_y increments and wraps from V_TOTAL-1 to 0.
- hsync is at level HS_POL when H_ACTIVE+H_FP <= pos_x < H_ACTIVE+H_FP+H_SYNC; otherwise it is at ~HS_POL.
- vsync is at level VS_POL when V_ACTIVE+V_FP <= pos_y < V_ACTIVE+V_FP+V_SYNC; it is line-granular and changes on the same edge as the pos_x wrap.
- frame_start and count:
  - frame_start is high exactly when the registered pos becomes (0, 0).
  - On that same edge, count increments and wraps from COUNT_MAX to 0.
  - count period is COUNT_MAX+1 frames (1 s at 60 Hz).
- Reset state, sampled while rst is high:
  - pos_x = H_TOTAL-1, pos_y = V_TOTAL-1
  - active = 0, hsync = ~HS_POL, vsync = ~VS_POL
  - count = COUNT_MAX, frame_start = 0
- First edge after reset release: pos = (0, 0), frame_start = 1, count = 0, active = 1.
- Reset mid-frame: takes effect on the next edge and overrides all counting. Partial frames are not completed.
- No enable input; the generator free-runs.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN
- Defined: hsync and vsync each pass through an additional SYNC_DLY-stage register pipeline, matching the renderer pipeline (register stage plus BRAM read). pos_x, pos_y, active, count and frame_start are not delayed.
  - Reset values of the delay stages: ~HS_POL for hsync, ~VS_POL for vsync.
- Undefined: no delay stages are instantiated and sync stays aligned with pos; SYNC_DLY is ignored.

Decomposition:
- Shared package vga_pkg holds:
  - the default 1440x900@60 timing constants
  - the coordinate width constant POS_W = 11
  - COUNT_W = 6
  - the blink threshold BLINK_HALF = 30, used by the renderers
- One sub-module, sig_delay: a parameterised-depth, parameterised-reset-value single-bit shift register with synchronous reset.
  - Instantiated twice under VGA_SYNC_DELAY_EN.

Test Plan:
- Reset then release -> first edge gives pos = (0, 0), frame_start = 1, count = 0, active = 1, hsync = 1, vsync = 0.
- Run one line -> active falls on the edge where pos_x = 1440; hsync is 0 for exactly 152 cycles starting at pos_x = 1520; pos_x wraps 1903 -> 0 with pos_y 0 -> 1.
- Run one frame -> vsync is 1 for exactly 6 lines (pos_y 903..908); frame_start recurs after 1904*934 = 1778336 cycles.
- Run 60 frames -> count goes 0..59 then returns to 0 on frame 60; count <= 30 is true for 31 of 60 frames.
- Assert rst at pos = (700, 450) for 1 cycle -> next outputs match the reset state; timing restarts cleanly from (0, 0).
- With VGA_SYNC_DELAY_EN and SYNC_DLY = 2 -> hsync falls at pos_x = 1522 while active/pos are unchanged versus the baseline run.
